exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM pipeline. Consumes the ID/EXE pipeline register outputs.
- Builds the second operand from the immediate, shifter or memory-offset field, then runs the ALU and updates the NZCV status register.
- Returns the branch target and the status flags to the IF and ID stages.
- Registers its results into the EXE/MEM pipeline register, which honours freeze from the cache/SRAM stall path.

---
 rtl/arm_pkg.sv | 19 +
 rtl/val2_gen.sv | 30 +++
 rtl/exe_stage.sv | 108 ++++++++++
 tb/tb_exe_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared ALU opcodes, shift types and forward-select codes
package arm_pkg;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;
endpackage

// File: rtl/val2_gen.sv
// val2_gen: combinational operand-2 generator (memory offset, rotated immediate, shifted register)
// Ports: mem - load/store offset mode; imm - immediate mode; so - 12-bit shifter field;
//        op2r - register operand; val2 - generated operand 2
module val2_gen
    import arm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          mem,
    input  logic          imm,
    input  logic [11:0]   so,
    input  logic [DW-1:0] op2r,
    output logic [DW-1:0] val2
);
    function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input logic [4:0] r);
        ror = (x >> r) | (x << (DW - int'(r)));
    endfunction

    logic [4:0] amt;

    always_comb begin
        amt = so[11:7];
        val2 = mem ? {{(DW-12){1'b0}}, so}
             : imm ? ror({{(DW-8){1'b0}}, so[7:0]}, {so[11:8], 1'b0})
             : so[6:5] == SH_LSL ? op2r << amt
             : so[6:5] == SH_LSR ? op2r >> amt
             : so[6:5] == SH_ASR ? $unsigned($signed(op2r) >>> amt)
             : ror(op2r, amt);
    end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage - operand select, ALU, NZCV status and EXE/MEM register
// Ports: clk/rst (sync active-high); freeze holds EXE/MEM and status; ID/EXE control, operands,
//        shifter field, branch offset and forwarding inputs; outputs branch_taken/branch_addr
//        (combinational), status (NZCV) and registered wb/mem controls, alu_res_out, st_val_out, dest_out.
// Macro EXE_FWD_EN: when defined, sel_src1/sel_src2 choose forwarded data; otherwise they are ignored.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          wb_en_in,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic          b_in,
    input  logic          s_in,
    input  logic          imm_in,
    input  logic [3:0]    exe_cmd,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] val_rn,
    input  logic [DW-1:0] val_rm,
    input  logic [11:0]   shift_operand,
    input  logic [23:0]   signed_imm_24,
    input  logic [RW-1:0] dest_in,
    input  logic [1:0]    sel_src1,
    input  logic [1:0]    sel_src2,
    input  logic [DW-1:0] fwd_mem_val,
    input  logic [DW-1:0] fwd_wb_val,
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr,
    output logic [3:0]    status,
    output logic          wb_en_out,
    output logic          mem_r_en_out,
    output logic          mem_w_en_out,
    output logic [DW-1:0] alu_res_out,
    output logic [DW-1:0] st_val_out,
    output logic [RW-1:0] dest_out
);
    logic [DW-1:0] op1, op2r, val2, res;
    logic [DW:0]   sum;
    logic          is_add, is_sub, c, v;

`ifdef EXE_FWD_EN
    assign op1  = sel_src1 == FWD_MEM ? fwd_mem_val : sel_src1 == FWD_WB ? fwd_wb_val : val_rn;
    assign op2r = sel_src2 == FWD_MEM ? fwd_mem_val : sel_src2 == FWD_WB ? fwd_wb_val : val_rm;
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, fwd_mem_val, fwd_wb_val};
    assign op1  = val_rn;
    assign op2r = val_rm;
`endif

    val2_gen #(.DW(DW)) u_val2 (
        .mem  (mem_r_en_in | mem_w_en_in),
        .imm  (imm_in),
        .so   (shift_operand),
        .op2r (op2r),
        .val2 (val2)
    );

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

    // Subtraction carry is the inverse of bit DW of the 33-bit difference (NOT borrow).
    always_comb begin
        is_add = exe_cmd == EXE_ADD || exe_cmd == EXE_ADC;
        is_sub = exe_cmd == EXE_SUB || exe_cmd == EXE_SBC;
        sum = exe_cmd == EXE_ADD ? {1'b0, op1} + {1'b0, val2}
            : exe_cmd == EXE_ADC ? {1'b0, op1} + {1'b0, val2} + {{DW{1'b0}}, status[1]}
            : exe_cmd == EXE_SUB ? {1'b0, op1} - {1'b0, val2}
            : exe_cmd == EXE_SBC ? {1'b0, op1} - {1'b0, val2} - {{DW{1'b0}}, ~status[1]}
            : '0;
        res = exe_cmd == EXE_MOV ? val2
            : exe_cmd == EXE_MVN ? ~val2
            : is_add || is_sub ? sum[DW-1:0]
            : exe_cmd == EXE_AND ? op1 & val2
            : exe_cmd == EXE_ORR ? op1 | val2
            : exe_cmd == EXE_EOR ? op1 ^ val2
            : '0;
        c = is_add ? sum[DW] : is_sub ? ~sum[DW] : status[1];
        v = is_add ? (op1[DW-1] == val2[DW-1]) && (res[DW-1] != op1[DW-1])
          : is_sub ? (op1[DW-1] != val2[DW-1]) && (res[DW-1] != op1[DW-1])
          : status[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status       <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res_out  <= '0;
            st_val_out   <= '0;
            dest_out     <= '0;
        end else if (!freeze) begin
            if (s_in) status <= {res[DW-1], res == '0, c, v};
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
            alu_res_out  <= res;
            st_val_out   <= op2r;
            dest_out     <= dest_in;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: table-driven self-checking bench for exe_stage plus freeze/reset/branch/forwarding sequences
module tb_exe_stage;
    import arm_pkg::*;

    logic        clk = 0, rst = 1, freeze = 0;
    logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, b_in = 0, s_in = 0, imm_in = 0;
    logic [3:0]  exe_cmd = 0;
    logic [31:0] pc_in = 0, val_rn = 0, val_rm = 0, fwd_mem_val = 0, fwd_wb_val = 0;
    logic [11:0] shift_operand = 0;
    logic [23:0] signed_imm_24 = 0;
    logic [3:0]  dest_in = 0;
    logic [1:0]  sel_src1 = 0, sel_src2 = 0;
    logic        branch_taken, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] branch_addr, alu_res_out, st_val_out;
    logic [3:0]  status, dest_out;

    int applied = 0, miscompares = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd(exe_cmd),
        .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res_out(alu_res_out), .st_val_out(st_val_out), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic        s, imm, mr, mw;
        logic [31:0] rn, rm;
        logic [11:0] so;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    vec_t vec[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic imm, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [11:0] so, input logic [3:0] d);
        exe_cmd = cmd; s_in = s; imm_in = imm; val_rn = rn; val_rm = rm;
        shift_operand = so; dest_in = d; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
    endtask

    initial begin
        vec[0]  = '{EXE_ADD, 1, 1, 0, 0, 32'h1,        32'h0,        12'h2FF, 32'hF0000010, 4'b1000};
        vec[1]  = '{EXE_SUB, 1, 0, 0, 0, 32'h5,        32'h5,        12'h000, 32'h0,        4'b0110};
        vec[2]  = '{EXE_ADC, 1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        12'h001, 32'h1,        4'b0010};
        vec[3]  = '{EXE_EOR, 1, 1, 0, 0, 32'hF0,       32'h0,        12'h00F, 32'hFF,       4'b0010};
        vec[4]  = '{EXE_ADD, 0, 0, 1, 0, 32'h100,      32'h0,        12'h804, 32'h904,      4'b0010};
        vec[5]  = '{EXE_MOV, 0, 0, 0, 0, 32'h0,        32'h1,        12'h200, 32'h10,       4'b0010};
        vec[6]  = '{EXE_MVN, 1, 0, 0, 0, 32'h0,        32'h80000000, 12'hFA0, 32'hFFFFFFFE, 4'b1010};
        vec[7]  = '{EXE_MOV, 0, 0, 0, 0, 32'h0,        32'h80000000, 12'h240, 32'hF8000000, 4'b1010};
        vec[8]  = '{EXE_MOV, 0, 0, 0, 0, 32'h0,        32'h0000000F, 12'h260, 32'hF0000000, 4'b1010};
        vec[9]  = '{EXE_SUB, 1, 1, 0, 0, 32'h80000000, 32'h0,        12'h001, 32'h7FFFFFFF, 4'b0011};
        vec[10] = '{EXE_ADD, 1, 1, 0, 0, 32'h7FFFFFFF, 32'h0,        12'h001, 32'h80000000, 4'b1001};
        vec[11] = '{EXE_SBC, 1, 1, 0, 0, 32'd10,       32'h0,        12'h003, 32'd6,        4'b0010};
        vec[12] = '{EXE_AND, 0, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 32'h0F000F00, 4'b0010};
        vec[13] = '{EXE_ORR, 0, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 32'hFFF0FFF0, 4'b0010};
        vec[14] = '{4'b0000, 1, 0, 0, 0, 32'h1234,     32'h5678,     12'h000, 32'h0,        4'b0110};
        vec[15] = '{EXE_ADD, 0, 0, 0, 1, 32'h200,      32'h0000DEAD, 12'h010, 32'h210,      4'b0110};
        vec[16] = '{EXE_SUB, 1, 1, 0, 0, 32'h1,        32'h0,        12'h002, 32'hFFFFFFFF, 4'b1000};

        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_res", alu_res_out, 0);
        chk("reset_status", {28'h0, status}, 0);
        chk("reset_ctrl", {29'h0, wb_en_out, mem_r_en_out, mem_w_en_out}, 0);

        for (int i = 0; i < 17; i++) begin
            drive(vec[i].cmd, vec[i].s, vec[i].imm, vec[i].rn, vec[i].rm, vec[i].so, 4'(i));
            mem_r_en_in = vec[i].mr;
            mem_w_en_in = vec[i].mw;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_res", i), alu_res_out, vec[i].res);
            chk($sformatf("vec%0d_status", i), {28'h0, status}, {28'h0, vec[i].st});
            chk($sformatf("vec%0d_st_val", i), st_val_out, vec[i].rm);
            chk($sformatf("vec%0d_ctrl", i), {28'h0, dest_out}, {28'h0, 4'(i)});
            chk($sformatf("vec%0d_mem", i), {30'h0, mem_r_en_out, mem_w_en_out}, {30'h0, vec[i].mr, vec[i].mw});
        end

        b_in = 1; pc_in = 32'h20; signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("branch_addr", branch_addr, 32'h18);
        chk("branch_taken", {31'h0, branch_taken}, 1);
        b_in = 0;

        drive(EXE_ADD, 1, 1, 32'h2, 32'h9, 12'h003, 4'd5);
        @(posedge clk);
        #1;
        chk("pre_freeze_res", alu_res_out, 5);
        chk("pre_freeze_status", {28'h0, status}, 0);
        freeze = 1;
        for (int k = 0; k < 3; k++) begin
            drive(EXE_MVN, 1, 1, 32'(k * 77 + 3), 32'(k + 100), 12'h000, 4'(k + 9));
            mem_w_en_in = 1;
            @(posedge clk);
            #1;
            chk($sformatf("freeze%0d_res", k), alu_res_out, 5);
            chk($sformatf("freeze%0d_status", k), {28'h0, status}, 0);
            chk($sformatf("freeze%0d_hold", k), {st_val_out[27:0], dest_out}, {28'h9, 4'd5});
            chk($sformatf("freeze%0d_mem", k), {31'h0, mem_w_en_out}, 0);
        end
        freeze = 0;
        drive(EXE_MVN, 1, 1, 32'h0, 32'h3, 12'h000, 4'd7);
        @(posedge clk);
        #1;
        chk("release_res", alu_res_out, 32'hFFFFFFFF);
        chk("release_status", {28'h0, status}, 32'h8);
        chk("release_dest", {28'h0, dest_out}, 7);
        freeze = 1; rst = 1;
        @(posedge clk);
        #1;
        chk("rst_freeze_res", alu_res_out, 0);
        chk("rst_freeze_status", {28'h0, status}, 0);
        chk("rst_freeze_other", {st_val_out[27:0], dest_out}, 0);
        chk("rst_freeze_ctrl", {29'h0, wb_en_out, mem_r_en_out, mem_w_en_out}, 0);
        freeze = 0; rst = 0;

        drive(EXE_ADD, 0, 1, 32'h2, 32'h11, 12'h001, 4'd3);
        sel_src1 = FWD_MEM; fwd_mem_val = 32'h7; sel_src2 = FWD_WB; fwd_wb_val = 32'h55;
        @(posedge clk);
        #1;
`ifdef EXE_FWD_EN
        chk("fwd_res", alu_res_out, 8);
        chk("fwd_st_val", st_val_out, 32'h55);
`else
        chk("fwd_res", alu_res_out, 3);
        chk("fwd_st_val", st_val_out, 32'h11);
`endif
        sel_src1 = 2'b11; sel_src2 = 2'b11;
        @(posedge clk);
        #1;
        chk("sel11_res", alu_res_out, 3);
        chk("sel11_st_val", st_val_out, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
